// File: rtl/if_fetch_queue.sv
// if_fetch_queue: owns the fetch PC, issues 1-cycle imem reads and
// buffers returned instructions with their PCs for the decode stage.
module if_fetch_queue #(
  parameter int unsigned     PC_W     = 9,
  parameter int unsigned     INS_W    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INS_W-1:0]           imem_rdata,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [INS_W-1:0]           id_instr,
  output logic [PC_W-1:0]            id_pc,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef logic [CW:0] need_t;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  pending_pc_q, pending_pc_d;
  logic             inflight_q, inflight_d;
  logic             kill_q, kill_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [INS_W-1:0] ins_q [DEPTH];
  logic [PC_W-1:0]  pcs_q [DEPTH];

  logic             pop;
  logic             push;
  logic             room;
  need_t            need;
  logic [PC_W-1:0]  redir_pc;

  assign id_valid  = (count_q != '0);
  assign pop       = id_valid & id_ready;
  assign push      = inflight_q & ~kill_q & ~rst & ~redirect;

  // Slots already promised: buffered plus in flight, minus this pop.
  assign need      = need_t'(count_q)
                   + need_t'(inflight_q)
                   - need_t'(pop);
  assign room      = (need < need_t'(DEPTH));
  assign imem_req  = ~rst & ~redirect & room;
  assign imem_addr = fetch_pc_q;

  assign redir_pc  = redirect_pc & ~PC_W'(3);

  assign id_instr  = id_valid ? ins_q[rd_ptr_q] : '0;
  assign id_pc     = id_valid ? pcs_q[rd_ptr_q] : '0;
  assign occupancy = count_q;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    inflight_d   = imem_req;
    kill_d       = 1'b0;
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    count_d      = count_q + CW'(push) - CW'(pop);
    if (imem_req) begin
      fetch_pc_d   = fetch_pc_q + PC_W'(4);
      pending_pc_d = fetch_pc_q;
    end
    if (redirect) begin
      fetch_pc_d = redir_pc;
      inflight_d = 1'b0;
      kill_d     = 1'b1;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      inflight_q   <= 1'b0;
      kill_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      inflight_q   <= inflight_d;
      kill_q       <= kill_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset; reads are masked by id_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ins_q[wr_ptr_q] <= imem_rdata;
      pcs_q[wr_ptr_q] <= pending_pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed stimulus with a PC scoreboard and a
// negedge monitor that checks every accepted decode transfer.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [8:0]  id_pc;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic [2:0]  occupancy;

  int          total = 0;
  int          bad   = 0;
  logic        mon_en = 1'b0;
  logic [8:0]  exp_q [$];
  logic [8:0]  mp;

  if_fetch_queue #(
    .PC_W(9), .INS_W(32), .DEPTH(4), .RESET_PC(9'h000)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [8:0] a);
    return {8'hA5, 7'h00, a, 8'h3C};
  endfunction

  // Memory answers only requested cycles; anything else is poison.
  always @(posedge clk)
    imem_rdata <= imem_req ? word(imem_addr) : 32'hDEADBEEF;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push_seq(input logic [8:0] start, input int n);
    logic [8:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 9'd4;
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 id_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("occ_le_depth", 32'(occupancy > 3'd4), 32'd0);
      if (!id_valid) begin
        chk("idle_pc", 32'(id_pc), 32'd0);
        chk("idle_instr", id_instr, 32'd0);
      end
      if (!rst && !redirect && id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got pc %0h want none",
                   id_pc);
        end else begin
          mp = exp_q.pop_front();
          chk("pop_pc", 32'(id_pc), 32'(mp));
          chk("pop_instr", id_instr, word(mp));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; id_ready = 1'b1;
    redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc", 32'(id_pc), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    mon_en = 1'b1;

    // sustained streaming from reset
    push_seq(9'h000, 4);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("p1_req", 32'(imem_req), 32'd1);
    chk("p1_addr", 32'(imem_addr), 32'd0);
    chk("p1_v0", 32'(id_valid), 32'd0);
    @(negedge clk);
    chk("p1_v1", 32'(id_valid), 32'd0);
    @(negedge clk);
    chk("p1_v2", 32'(id_valid), 32'd1);
    chk("p1_pc0", 32'(id_pc), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("p1_stream", 32'(id_valid), 32'd1);
    end
    @(posedge clk); #1 id_ready = 1'b0;
    @(negedge clk); #1;
    chk("p1_drained", 32'(exp_q.size()), 32'd0);

    // fill to full with decode stalled, then drain
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("p2_occ", 32'(occupancy), 32'd4);
    chk("p2_req", 32'(imem_req), 32'd0);
    chk("p2_addr", 32'(imem_addr), 32'h10);
    push_seq(9'h000, 8);
    @(posedge clk); #1 id_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("p2_nogap", 32'(id_valid), 32'd1);
    end
    @(posedge clk); #1 id_ready = 1'b0;
    @(negedge clk); #1;
    chk("p2_drained", 32'(exp_q.size()), 32'd0);

    // full FIFO with ready toggling
    repeat (4) @(negedge clk);
    chk("p3_occ", 32'(occupancy), 32'd4);
    chk("p3_addr", 32'(imem_addr), 32'h30);
    push_seq(9'h020, 8);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1 id_ready = (i % 2 == 0);
    end
    @(negedge clk); #1;
    chk("p3_drained", 32'(exp_q.size()), 32'd0);

    // redirect with 3 buffered and one in flight
    repeat (4) @(negedge clk);
    chk("p4_full", 32'(occupancy), 32'd4);
    chk("p4_addr", 32'(imem_addr), 32'h50);
    push_seq(9'h040, 1);
    @(posedge clk); #1 id_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = 9'h047;
    @(negedge clk);
    chk("p4_occ3", 32'(occupancy), 32'd3);
    chk("p4_redir_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    redirect = 1'b0;
    push_seq(9'h044, 3);
    id_ready = 1'b1;
    @(negedge clk);
    chk("p4_v_r1", 32'(id_valid), 32'd0);
    chk("p4_occ0", 32'(occupancy), 32'd0);
    chk("p4_req", 32'(imem_req), 32'd1);
    chk("p4_addr44", 32'(imem_addr), 32'h44);
    @(negedge clk);
    chk("p4_v_r2", 32'(id_valid), 32'd0);
    @(negedge clk);
    chk("p4_v_r3", 32'(id_valid), 32'd1);
    chk("p4_pc44", 32'(id_pc), 32'h44);
    wait_drain("p4_drained");

    // back-to-back redirects, last one wraps the PC space
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 9'h100;
    @(posedge clk); #1 redirect_pc = 9'h1FE;
    @(posedge clk); #1;
    redirect = 1'b0;
    push_seq(9'h1FC, 3);
    id_ready = 1'b1;
    @(negedge clk);
    chk("p5_req", 32'(imem_req), 32'd1);
    chk("p5_addr", 32'(imem_addr), 32'h1FC);
    wait_drain("p5_drained");

    // reset together with redirect mid-stream
    repeat (4) @(negedge clk);
    chk("p6_occ", 32'(occupancy), 32'd4);
    push_seq(9'h008, 2);
    @(posedge clk); #1 id_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; redirect = 1'b1; redirect_pc = 9'h080;
    @(negedge clk);
    chk("p6_rst_req", 32'(imem_req), 32'd0);
    chk("p6_pre", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; redirect = 1'b0;
    push_seq(9'h000, 3);
    @(negedge clk);
    chk("p6_valid", 32'(id_valid), 32'd0);
    chk("p6_pc", 32'(id_pc), 32'd0);
    chk("p6_instr", id_instr, 32'd0);
    chk("p6_occ0", 32'(occupancy), 32'd0);
    chk("p6_req", 32'(imem_req), 32'd1);
    chk("p6_addr", 32'(imem_addr), 32'd0);
    wait_drain("p6_drained");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
